// File: rtl/lz77_pkg.sv
// Shared constants, state encoding and ring-pointer helper for the LZ77 stream encoder.
package lz77_pkg;
    localparam int CHAR_W     = 8;
    localparam int SEARCH_LEN = 9;
    localparam int LOOK_LEN   = 8;
    localparam int OFFSET_W   = 4;
    localparam int MLEN_W     = 3;
    localparam int DEPTH      = SEARCH_LEN + LOOK_LEN;
    localparam int PTR_W      = 5;
    localparam int CNT_W      = 4;

    localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

    typedef enum logic [2:0] {
        FILL,
        SEARCH,
        EMIT,
        SHIFT,
        DONE
    } state_t;

    // Ring-buffer index arithmetic; delta is always non-negative.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int delta);
        int sum;
        sum = (int'(base) + delta) % DEPTH;
        return PTR_W'(sum);
    endfunction
endpackage

// File: rtl/lz77_match_len.sv
// Combinational prefix compare: counts leading equal char pairs, stopping at cap.
module lz77_match_len
    import lz77_pkg::*;
(
    input  logic [LOOK_LEN-1:0][CHAR_W-1:0] cand,
    input  logic [LOOK_LEN-1:0][CHAR_W-1:0] look,
    input  logic [MLEN_W-1:0]               cap,
    output logic [MLEN_W-1:0]               len
);
    logic run;

    always_comb begin
        len = '0;
        run = 1'b1;
        for (int i = 0; i < LOOK_LEN - 1; i++) begin
            if (run && (MLEN_W'(i) < cap) && (cand[i] == look[i])) begin
                len = len + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end
endmodule

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: ring-buffer window, serial offset search, one token per step.
module lz77_stream_encoder
    import lz77_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CHAR_W-1:0]   chardata,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OFFSET_W-1:0] offset,
    output logic [MLEN_W-1:0]   match_len,
    output logic [CHAR_W-1:0]   char_nxt,
    output logic                encode,
    output logic                finish
);
    state_t                           state;
    logic [CHAR_W-1:0]                win [DEPTH];
    logic [PTR_W-1:0]                 head;
    logic [CNT_W-1:0]                 hist_cnt;
    logic [CNT_W-1:0]                 look_cnt;
    logic                             end_stored;
    logic [OFFSET_W-1:0]              k;
    logic [OFFSET_W-1:0]              best_off;
    logic [MLEN_W-1:0]                best_len;

    logic [LOOK_LEN-1:0][CHAR_W-1:0]  look_vec;
    logic [LOOK_LEN-1:0][CHAR_W-1:0]  cand_vec;
    logic [MLEN_W-1:0]                cap;
    logic [MLEN_W-1:0]                cur_len;
    logic                             cap_found;
    logic                             upd;
    logic [MLEN_W-1:0]                fin_len;
    logic [OFFSET_W-1:0]              fin_off;
    logic                             accept;
    logic [CNT_W:0]                   hist_sum;
    logic [CNT_W-1:0]                 step;

    assign encode   = 1'b1;
    assign in_ready = !reset && (state == FILL) && (look_cnt < CNT_W'(LOOK_LEN)) && !end_stored;
    assign accept   = in_valid && in_ready;
    assign step     = {1'b0, best_len} + 1'b1;
    assign hist_sum = {1'b0, hist_cnt} + {1'b0, step};

    // Candidate start sits k+1 chars behind head; it may run on into the lookahead.
    always_comb begin
        for (int i = 0; i < LOOK_LEN; i++) begin
            look_vec[i] = win[ptr_add(head, i)];
            cand_vec[i] = win[ptr_add(head, DEPTH - 1 - int'(k) + i)];
        end
    end

    always_comb begin
        cap       = MLEN_W'(LOOK_LEN - 1);
        cap_found = 1'b0;
        for (int i = 0; i < LOOK_LEN; i++) begin
            if (!cap_found && (CNT_W'(i) < look_cnt) && (look_vec[i] == END_CHAR)) begin
                cap       = MLEN_W'(i);
                cap_found = 1'b1;
            end
        end
    end

    lz77_match_len u_match_len (
        .cand (cand_vec),
        .look (look_vec),
        .cap  (cap),
        .len  (cur_len)
    );

    assign upd     = (k < hist_cnt) && (cur_len > best_len);
    assign fin_len = upd ? cur_len : best_len;
    assign fin_off = upd ? k : best_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            head       <= '0;
            hist_cnt   <= '0;
            look_cnt   <= '0;
            end_stored <= 1'b0;
            k          <= '0;
            best_off   <= '0;
            best_len   <= '0;
            out_valid  <= 1'b0;
            offset     <= '0;
            match_len  <= '0;
            char_nxt   <= '0;
            finish     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        win[ptr_add(head, int'(look_cnt))] <= chardata;
                        look_cnt <= look_cnt + 1'b1;
                        if (chardata == END_CHAR) end_stored <= 1'b1;
                    end
                    if ((accept && ((look_cnt == CNT_W'(LOOK_LEN - 1)) || (chardata == END_CHAR)))
                        || (look_cnt == CNT_W'(LOOK_LEN)) || end_stored) begin
                        state    <= SEARCH;
                        k        <= '0;
                        best_off <= '0;
                        best_len <= '0;
                    end
                end
                SEARCH: begin
                    best_off <= fin_off;
                    best_len <= fin_len;
                    if (k == OFFSET_W'(SEARCH_LEN - 1)) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        offset    <= fin_off;
                        match_len <= fin_len;
                        char_nxt  <= look_vec[fin_len];
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        offset    <= '0;
                        match_len <= '0;
                        char_nxt  <= '0;
                        if (char_nxt == END_CHAR) finish <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    head     <= ptr_add(head, int'(step));
                    hist_cnt <= (hist_sum > (CNT_W + 1)'(SEARCH_LEN)) ? CNT_W'(SEARCH_LEN)
                                                                       : hist_sum[CNT_W-1:0];
                    look_cnt <= look_cnt - step;
                    state    <= finish ? DONE : FILL;
                end
                DONE: state <= DONE;
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Directed bench for lz77_stream_encoder: string stimuli with hand-computed token lists.
module tb_lz77_stream_encoder;
    import lz77_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [CHAR_W-1:0]   chardata;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [OFFSET_W-1:0] offset;
    logic [MLEN_W-1:0]   match_len;
    logic [CHAR_W-1:0]   char_nxt;
    logic                encode;
    logic                finish;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_off[$];
    int exp_len[$];
    int exp_ch[$];

    always #5 clk = ~clk;

    lz77_stream_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .chardata  (chardata),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .offset    (offset),
        .match_len (match_len),
        .char_nxt  (char_nxt),
        .encode    (encode),
        .finish    (finish)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic push_tok(input int o, input int l, input int c);
        exp_off.push_back(o);
        exp_len.push_back(l);
        exp_ch.push_back(c);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_out_valid"}, int'(out_valid), 0);
        check_val({tag, "_finish"}, int'(finish), 0);
        check_val({tag, "_in_ready"}, int'(in_ready), 0);
        check_val({tag, "_fields"}, int'({offset, match_len, char_nxt}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check_val("encode", int'(encode), 1);
        reset = 1'b0;
    endtask

    // Feeds s (then holds in_valid high with junk), drains tokens, stalls token stall_tok for 5 cycles.
    task automatic run_enc(input string name, input string s, input int stall_tok);
        int idx   = 0;
        int t     = 0;
        int stall = 0;
        int cyc   = 0;
        while (!finish && cyc < 400) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            chardata = (idx < s.len()) ? s[idx] : 8'h7a;
            if (in_ready) idx++;
            if (out_valid && t == stall_tok && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                check_val({name, "_stall_off"}, int'(offset), exp_off[t]);
                check_val({name, "_stall_len"}, int'(match_len), exp_len[t]);
                check_val({name, "_stall_chr"}, int'(char_nxt), exp_ch[t]);
                check_val({name, "_stall_inrdy"}, int'(in_ready), 0);
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    if (t < exp_off.size()) begin
                        check_val($sformatf("%s_tok%0d_off", name, t), int'(offset), exp_off[t]);
                        check_val($sformatf("%s_tok%0d_len", name, t), int'(match_len), exp_len[t]);
                        check_val($sformatf("%s_tok%0d_chr", name, t), int'(char_nxt), exp_ch[t]);
                    end else begin
                        check_val({name, "_extra_token"}, t, exp_off.size() - 1);
                    end
                    t++;
                end
            end
        end
        check_val({name, "_finish"}, int'(finish), 1);
        check_val({name, "_tokens"}, t, exp_off.size());
        check_val({name, "_accepted"}, idx, s.len());
        if (stall_tok >= 0) check_val({name, "_stall_cycles"}, stall, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val({name, "_done_inrdy"}, int'(in_ready), 0);
            check_val({name, "_done_ovalid"}, int'(out_valid), 0);
            check_val({name, "_done_finish"}, int'(finish), 1);
        end
        in_valid = 1'b0;
        exp_off.delete();
        exp_len.delete();
        exp_ch.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        chardata  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        do_reset();
        push_tok(0, 0, "a"); push_tok(0, 1, "b"); push_tok(0, 0, "$");
        run_enc("aab", "aab$", -1);

        do_reset();
        push_tok(0, 0, "a"); push_tok(0, 7, "a"); push_tok(0, 1, "$");
        run_enc("a10", "aaaaaaaaaa$", -1);

        do_reset();
        push_tok(0, 0, "a"); push_tok(0, 0, "X"); push_tok(1, 1, "Y"); push_tok(1, 1, "$");
        run_enc("tie", "aXaYa$", 2);

        do_reset();
        push_tok(0, 0, "$");
        run_enc("end_only", "$", -1);

        // Abort an encode in the middle of its search phase.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        chardata = "$";
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        reset = 1'b0;
        push_tok(0, 0, "a"); push_tok(0, 0, "b"); push_tok(0, 0, "$");
        run_enc("after_rst", "ab$", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
